// File: rtl/program_loader_if.sv
// Byte-stream and instruction-memory write bundle between a program source and the loader.
// A byte transfers on a rising edge where ByteValid and ByteReady are both 1; the source holds ByteIn/ByteValid until then.
interface program_loader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) ();
  logic              Start;
  logic [7:0]        ByteIn;
  logic              ByteValid;
  logic              ByteReady;
  logic [ADDR_W-1:0] IM_Addr;
  logic [DATA_W-1:0] IM_Data;
  logic              IM_Wr;
  logic              ProcReset;
  logic              Done;
  logic              Err;
  logic [ADDR_W:0]   WordCount;
  logic [2:0]        DbgState;

  modport slave (
    input  Start, ByteIn, ByteValid,
    output ByteReady, IM_Addr, IM_Data, IM_Wr, ProcReset, Done, Err, WordCount, DbgState
  );

  modport master (
    output Start, ByteIn, ByteValid,
    input  ByteReady, IM_Addr, IM_Data, IM_Wr, ProcReset, Done, Err, WordCount, DbgState
  );
endinterface

// File: rtl/program_loader.sv
// Framed byte-stream loader: writes [count][hi lo]...[chk] into instruction memory and
// keeps the processor in reset until the XOR checksum of the instruction bytes verifies.
module program_loader #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 16,
  parameter int MAX_WORDS = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  program_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_WRITE = 3'd3,
    S_CHK   = 3'd4,
    S_RUN   = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam logic [7:0] MAX_BYTE = 8'(MAX_WORDS);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [7:0]        chk_q, chk_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic              ready;
  logic              accept;

  assign ready  = (state_q == S_IDLE) || (state_q == S_HI) ||
                  (state_q == S_LO)   || (state_q == S_CHK);
  assign accept = bus.ByteValid && ready;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      index_q <= '0;
      chk_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      chk_q   <= chk_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    index_d = index_q;
    chk_d   = chk_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    wcnt_d  = wcnt_q;

    // Start wins over a byte accepted in the same cycle.
    if (bus.Start) begin
      state_d = S_IDLE;
      count_d = '0;
      index_d = '0;
      chk_d   = '0;
      addr_d  = '0;
      data_d  = '0;
      wcnt_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            count_d = bus.ByteIn[ADDR_W:0];
            if (bus.ByteIn == 8'd0 || bus.ByteIn > MAX_BYTE) begin
              state_d = S_ERR;
            end else begin
              state_d = S_HI;
              index_d = '0;
              chk_d   = '0;
            end
          end
        end
        S_HI: begin
          if (accept) begin
            data_d[DATA_W-1:DATA_W-8] = bus.ByteIn;
            chk_d   = chk_q ^ bus.ByteIn;
            state_d = S_LO;
          end
        end
        S_LO: begin
          if (accept) begin
            data_d[7:0] = bus.ByteIn;
            chk_d   = chk_q ^ bus.ByteIn;
            addr_d  = index_q;
            wr_d    = 1'b1;
            wcnt_d  = {1'b0, index_q} + 1'b1;
            state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          // Last word goes to CHK so index never advances past count-1.
          if ({1'b0, index_q} == count_q - 1'b1) begin
            state_d = S_CHK;
          end else begin
            index_d = index_q + 1'b1;
            state_d = S_HI;
          end
        end
        S_CHK: begin
          if (accept) begin
            state_d = (bus.ByteIn == chk_q) ? S_RUN : S_ERR;
          end
        end
        S_RUN:   state_d = S_RUN;
        S_ERR:   state_d = S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.ByteReady = ready;
  assign bus.IM_Addr   = addr_q;
  assign bus.IM_Data   = data_q;
  assign bus.IM_Wr     = wr_q;
  assign bus.ProcReset = (state_q != S_RUN);
  assign bus.Done      = (state_q == S_RUN);
  assign bus.Err       = (state_q == S_ERR);
  assign bus.WordCount = wcnt_q;
  assign bus.DbgState  = state_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream instruction loader: receives a framed program over a valid/ready byte interface and writes it into the processor's 32x16 instruction memory.
- Holds the processor in reset while loading.
- Releases the processor only after a complete, checksum-verified load.
- It is the writer side of the instruction memory that the processor's PC/IR fetch path reads.

Parameters:
ADDR_W, 5, instruction memory address width (matches PC width)
DATA_W, 16, instruction word width (matches IR width)
MAX_WORDS, 32, largest legal word count in a frame (2**ADDR_W)

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  asynchronous, active-low reset
Start  input  1  single-cycle pulse; aborts any activity and returns to IDLE
ByteIn  input  8  incoming stream byte
ByteValid  input  1  ByteIn valid
ByteReady  output  1  loader can accept a byte this cycle
IM_Addr  output  ADDR_W  instruction memory write address
IM_Data  output  DATA_W  instruction memory write data
IM_Wr  output  1  instruction memory write strobe, one cycle per word
ProcReset  output  1  active-high reset driven to the processor
Done  output  1  load verified, processor running
Err  output  1  frame error (bad count or checksum)
WordCount  output  ADDR_W+1  number of words written so far

Behaviour:
- Reset (Reset=0, asynchronous):
  - State=IDLE; IM_Addr=0, IM_Data=0, IM_Wr=0, Done=0, Err=0, WordCount=0.
  - ProcReset=1; internal count, index and checksum cleared.
- Handshake: a byte transfers on a rising edge with ByteValid=1 and ByteReady=1. ByteReady is combinational from state: 1 in IDLE, HI, LO, CHK; 0 elsewhere.
- Frame format: [count][hi0][lo0]...[hi(n-1)][lo(n-1)][chk]. chk = XOR of all instruction bytes; the count byte is excluded.
- States:
  - IDLE: on accept, latch count. count==0 or count>MAX_WORDS -> ERR. Else -> HI; index=0, checksum=0.
  - HI: on accept, IM_Data[15:8]=ByteIn, checksum^=ByteIn -> LO.
  - LO: on accept, IM_Data[7:0]=ByteIn, checksum^=ByteIn, IM_Addr=index -> WRITE.
  - WRITE (exactly one cycle): IM_Wr=1, WordCount=index+1. If index==count-1 -> CHK, else index+1 and -> HI.
  - CHK: on accept, ByteIn==checksum -> RUN, else -> ERR.
  - RUN: ProcReset=0, Done=1; holds until Start or Reset.
  - ERR: Err=1, ProcReset=1; holds until Start or Reset.
- Latency: the write strobe is asserted the cycle after the low byte is accepted. The processor leaves reset the cycle after the checksum byte is accepted.
- IM_Wr is registered and high only in WRITE. IM_Addr and IM_Data are held stable while IM_Wr=1.
- Start has priority over any byte acceptance in the same cycle. In any state it goes to IDLE with the reset values above: ProcReset=1, Done=0, Err=0, WordCount=0.
- Memory already written by an aborted or failed load is not cleared; the processor stays in reset until a later frame verifies.
- ByteValid while ByteReady=0 (WRITE, RUN, ERR): byte is not consumed; the sender must hold it.
- Reset asserted mid-frame: immediate return to IDLE. A partial frame is discarded and the next byte is taken as a count.
- Boundaries:
  - count==MAX_WORDS: last write at IM_Addr=31; index does not wrap past count-1.
  - WordCount reaches 32 and needs ADDR_W+1 bits.

Test Plan:
- Reset low then high, ByteValid=0 -> ProcReset=1, Done=0, Err=0, ByteReady=1, IM_Wr never pulses.
- Frame 02,12,34,AB,CD,40 sent back-to-back:
  - IM_Wr pulses twice: addr0=1234, then addr1=ABCD.
  - WordCount=2.
  - Cycle after 40 accepted: ProcReset=0, Done=1.
- Same frame with chk=41 -> both words written, then Err=1, ProcReset stays 1, Done=0. Start pulse -> Err=0, ByteReady=1.
- Count byte 00, and separately count byte 21 (33) -> ERR immediately, no IM_Wr. Any later bytes are refused (ByteReady=0) until Start.
- ByteValid held high continuously with data changing only on accepted edges -> ByteReady drops for each WRITE cycle and no byte is lost or duplicated; a 32-word frame ends with the last write at addr 31 and WordCount=32.
- Reset pulsed low after 3 bytes of a frame -> IDLE, WordCount=0. A fresh 01,00,FF,FF frame then loads addr0=00FF and reaches RUN.
